// File: rtl/dmem_arbiter_if.sv
// Requester and memory-pin bundle for dmem_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if;
    logic        iReq0,   iReq1;
    logic        iWe0,    iWe1;
    logic [1:0]  iSize0,  iSize1;
    logic        iUns0,   iUns1;
    logic [31:0] iAddr0,  iAddr1;
    logic [31:0] iWdata0, iWdata1;
    logic        oAck0,   oAck1;
    logic [31:0] oRdata0, oRdata1;
    logic        oErr0,   oErr1;
    logic        oMemWrite;
    logic        oMemRead;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWdata;
    logic [31:0] iMemRdata;

    modport slave (
        input  iReq0, iReq1, iWe0, iWe1, iSize0, iSize1,
        input  iUns0, iUns1, iAddr0, iAddr1, iWdata0, iWdata1,
        input  iMemRdata,
        output oAck0, oAck1, oRdata0, oRdata1, oErr0, oErr1,
        output oMemWrite, oMemRead, oMemAddr, oMemWdata
    );

    modport master (
        output iReq0, iReq1, iWe0, iWe1, iSize0, iSize1,
        output iUns0, iUns1, iAddr0, iAddr1, iWdata0, iWdata1,
        output iMemRdata,
        input  oAck0, oAck1, oRdata0, oRdata1, oErr0, oErr1,
        input  oMemWrite, oMemRead, oMemAddr, oMemWdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin data-memory arbiter with sub-word read-modify-write.
// Define DMEM_ALIGN_TRAP_EN to error-ack misaligned half/word accesses.
module dmem_arbiter #(
    parameter int MEM_WORDS = 256
) (
    input  logic           clock,
    input  logic           reset_n,
    dmem_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam logic [31:0] AMASK = 32'(MEM_WORDS * 4 - 1) & ~32'd3;

    logic [1:0]  r_state;
    logic        r_port;
    logic        r_last;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic        r_err;

    logic        w_any;
    logic        w_gnt;
    logic        w_we;
    logic [1:0]  w_size;
    logic        w_uns;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_mis;

    assign w_any   = bus.iReq0 | bus.iReq1;
    // r_last holds the previous winner; a tie goes to the other port
    assign w_gnt   = (bus.iReq0 & bus.iReq1) ? ~r_last : bus.iReq1;
    assign w_we    = w_gnt ? bus.iWe1    : bus.iWe0;
    assign w_size  = w_gnt ? bus.iSize1  : bus.iSize0;
    assign w_uns   = w_gnt ? bus.iUns1   : bus.iUns0;
    assign w_addr  = w_gnt ? bus.iAddr1  : bus.iAddr0;
    assign w_wdata = w_gnt ? bus.iWdata1 : bus.iWdata0;

`ifdef DMEM_ALIGN_TRAP_EN
    assign w_mis = (w_size == 2'b01 && w_addr[0])
                 | (w_size[1] && w_addr[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_port  <= 1'b0;
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_word  <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_port  <= w_gnt;
                        r_last  <= w_gnt;
                        r_we    <= w_we;
                        r_size  <= w_size;
                        r_uns   <= w_uns;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_err   <= w_mis;
                        if (w_mis)
                            r_state <= S_RESP;
                        else if (!w_we || !w_size[1])
                            r_state <= S_READ;
                        else
                            r_state <= S_WRITE;
                    end
                end
                S_READ: begin
                    r_word  <= bus.iMemRdata;
                    r_state <= r_we ? S_WRITE : S_RESP;
                end
                S_WRITE: r_state <= S_RESP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic [4:0]  w_sh;
    logic [31:0] w_mask;
    logic [31:0] w_merge;
    logic [31:0] w_lane;
    logic [31:0] w_load;
    logic [31:0] w_resp;
    logic        w_ack0;
    logic        w_ack1;

    always_comb begin
        w_sh   = 5'd0;
        w_mask = 32'hFFFF_FFFF;
        if (!r_size[1] && r_size[0]) begin
            w_sh   = {r_addr[1], 4'b0000};
            w_mask = 32'h0000_FFFF << w_sh;
        end else if (!r_size[1]) begin
            w_sh   = {r_addr[1:0], 3'b000};
            w_mask = 32'h0000_00FF << w_sh;
        end
    end

    assign w_merge = (r_word & ~w_mask) | ((r_wdata << w_sh) & w_mask);
    assign w_lane  = r_word >> w_sh;

    always_comb begin
        w_load = r_word;
        if (!r_size[1] && r_size[0])
            w_load = {{16{~r_uns & w_lane[15]}}, w_lane[15:0]};
        else if (!r_size[1])
            w_load = {{24{~r_uns & w_lane[7]}}, w_lane[7:0]};
    end

    assign w_resp = (r_we | r_err) ? 32'd0 : w_load;
    assign w_ack0 = (r_state == S_RESP) & ~r_port;
    assign w_ack1 = (r_state == S_RESP) &  r_port;

    assign bus.oAck0     = w_ack0;
    assign bus.oAck1     = w_ack1;
    assign bus.oRdata0   = w_ack0 ? w_resp : 32'd0;
    assign bus.oRdata1   = w_ack1 ? w_resp : 32'd0;
    assign bus.oErr0     = w_ack0 & r_err;
    assign bus.oErr1     = w_ack1 & r_err;
    assign bus.oMemRead  = (r_state == S_READ);
    assign bus.oMemWrite = (r_state == S_WRITE);
    assign bus.oMemAddr  = (r_state == S_READ || r_state == S_WRITE)
                         ? (r_addr & AMASK) : 32'd0;
    assign bus.oMemWdata = (r_state == S_WRITE) ? w_merge : 32'd0;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory.
- Shares the memory between the CPU load/store unit (port 0) and the debug/program loader (port 1).
- Converts byte, halfword and word requests into word accesses. Sub-word stores use read-modify-write.
- Drives the memory's write/read/address/data pins and captures its read data.

Parameters:
MEM_WORDS, 256, number of 32-bit words in the memory; must be a power of two; byte addresses wrap modulo MEM_WORDS*4.

Ports:
clock  in  1  system clock; the memory reads on negedge and writes on posedge of this clock
reset_n  in  1  asynchronous active-low reset
iReq0/iReq1  in  1  request; held high until the matching ack
iWe0/iWe1  in  1  1=store, 0=load
iSize0/iSize1  in  2  00 byte, 01 half, 10 word, 11 treated as word
iUns0/iUns1  in  1  load zero-extend (1) / sign-extend (0)
iAddr0/iAddr1  in  32  byte address
iWdata0/iWdata1  in  32  store data, right-justified
oAck0/oAck1  out  1  one-cycle completion pulse
oRdata0/oRdata1  out  32  load result, valid while ack is high
oErr0/oErr1  out  1  error flag, valid while ack is high
oMemWrite  out  1  to memory write
oMemRead  out  1  to memory read
oMemAddr  out  32  word-aligned byte address to memory, low 2 bits always 0
oMemWdata  out  32  to memory data in
iMemRdata  in  32  from memory data out

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer set so port 0 wins the first tie. Reset asserted mid-operation aborts immediately: oMemWrite drops asynchronously, no ack is issued, the request is lost. Requesters must re-request.
- Registered FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - Single request: grant it. Both requesting: grant the port not granted last, then update the pointer.
  - Latch port id, we, size, uns, addr, wdata.
  - Next state: load or sub-word store -> READ; word store -> WRITE; no request -> stay.
- READ:
  - oMemRead=1, oMemAddr={addr[31:2],2'b00} masked to MEM_WORDS range.
  - At the following posedge, capture iMemRdata into an internal word register.
  - Next state: load -> RESP; store -> WRITE.
- WRITE:
  - oMemWrite=1, oMemWdata = merged word. Word store: wdata. Half store: wdata[15:0] into lane addr[1]. Byte store: wdata[7:0] into lane addr[1:0]. Other lanes come from the captured word.
  - Next state: RESP.
- RESP:
  - oAck of the granted port=1 for exactly this cycle.
  - Load: oRdata = selected lane shifted to bit 0, sign- or zero-extended per uns (word: unchanged). Store: oRdata=0.
  - Next state: IDLE. A request seen during RESP is not granted until IDLE.
- oMemRead and oMemWrite are never high together. Both are low in IDLE and RESP. Memory pins are driven only for the granted port; the other port's oAck/oRdata stay 0.
- Latency from the posedge that samples iReq in IDLE to the ack cycle:
  - load: 2 cycles (READ, RESP)
  - word store: 2 cycles (WRITE, RESP)
  - sub-word store: 3 cycles (READ, WRITE, RESP)
- Throughput: at most one access in flight. A requester must deassert or change its request in the cycle after ack; a request still high is treated as a new request.
- Misaligned accesses (without macro): half ignores addr[0]; word ignores addr[1:0]. Access proceeds aligned, oErr=0.

Optional Feature:
- Macro: DMEM_ALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, goes IDLE -> RESP directly.
  - No memory read or write occurs.
  - Ack is issued 1 cycle after grant with oErr=1 and oRdata=0.
  - The round-robin pointer still updates.
- Undefined: oErr0/oErr1 tied to 0; aligned-forcing behaviour above.

Test Plan:
- Reset, then port0 word store 0xDEADBEEF @0x10, then word load @0x10 -> each ack 2 cycles after grant; rdata=0xDEADBEEF; oMemWrite high exactly 1 cycle with oMemAddr=0x10.
- Preload 0x11223344 @0x20. Byte store 0xAA @0x21, then load word -> 0x1122AA44, store ack 3 cycles after grant. Load byte signed @0x21 -> 0xFFFFFFAA. Load half unsigned @0x22 -> 0x00001122.
- Both ports request continuously from reset -> grants alternate 0,1,0,1. No port gets two consecutive grants while the other waits. oMemRead and oMemWrite are never both high.
- Assert reset_n=0 during the WRITE state of a sub-word store -> oMemWrite drops the same cycle, no ack, outputs 0. A load after reset returns the old memory word.
- Half load @0x13 -> macro off: ack 2 cycles after grant with the half from 0x12, oErr=0; macro on: ack 1 cycle after grant, oErr=1, rdata=0, no memory access.
- Word load @MEM_WORDS*4+8 -> returns the word at address 0x8 (wrap).
